// File: rtl/register_scatter_pkg.sv
// Shared types and helpers for register_scatter: slot index, slot state, count width.
package register_scatter_pkg;

  localparam int unsigned SLOTS   = 4;
  localparam int unsigned COUNT_W = 3;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [COUNT_W-1:0] popcount4(input logic [SLOTS-1:0] v);
    logic [COUNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      c = c + COUNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/register_scatter_slot.sv
// One holding slot: n-bit data plus EMPTY/FULL state with reset > write/ack priority.
module register_slot
  import register_scatter_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         write,
  input  logic         ack,
  input  logic [n-1:0] in,
  output logic [n-1:0] out,
  output logic         full
);

  slot_state_t state, state_next;

  always_ff @(posedge clock) begin
    if (reset) state <= SLOT_EMPTY;
    else       state <= state_next;
  end

  // A write to a FULL slot only happens alongside its ack, so FULL simply stays FULL.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (write)        state_next = SLOT_FULL;
      SLOT_FULL:  if (ack && !write) state_next = SLOT_EMPTY;
      default:                      state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)      out <= '0;
    else if (write) out <= in;
  end

  assign full = (state == SLOT_FULL);

endmodule

// File: rtl/register_scatter.sv
// Scatters one word per cycle into one of four acknowledged holding slots.
// Optional sticky overflow flag under `REGISTER_SCATTER_OVERFLOW_EN.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module register_scatter
  import register_scatter_pkg::*;
#(
  parameter int unsigned n = `DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
`ifdef REGISTER_SCATTER_OVERFLOW_EN
  input  logic               overflow_clear,
  output logic               overflow,
`endif
  input  logic               load,
  input  logic [1:0]         select,
  input  logic [n-1:0]       in,
  output logic               ready,
  output logic [n-1:0]       out0,
  output logic [n-1:0]       out1,
  output logic [n-1:0]       out2,
  output logic [n-1:0]       out3,
  output logic [SLOTS-1:0]   full,
  input  logic [SLOTS-1:0]   ack,
  output logic [COUNT_W-1:0] count
);

  slot_idx_t          sel;
  logic               accept;
  logic [SLOTS-1:0]   wr;
  logic [n-1:0]       slot_data [SLOTS];
  logic [COUNT_W-1:0] inc, dec, count_next;

  assign sel    = select;
  assign ready  = ~full[sel] | ack[sel];
  assign accept = load & ready;

  always_comb begin
    wr = '0;
    if (accept) wr[sel] = 1'b1;
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    register_slot #(.n(n)) u_slot (
      .clock (clock),
      .reset (reset),
      .write (wr[i]),
      .ack   (ack[i]),
      .in    (in),
      .out   (slot_data[i]),
      .full  (full[i])
    );
  end

  assign out0 = slot_data[0];
  assign out1 = slot_data[1];
  assign out2 = slot_data[2];
  assign out3 = slot_data[3];

  // Consumes coinciding with a write to the same slot cancel out and are not counted.
  always_comb begin
    inc        = COUNT_W'(accept & ~full[sel]);
    dec        = popcount4(ack & full & ~wr);
    count_next = count + inc - dec;
  end

  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

`ifdef REGISTER_SCATTER_OVERFLOW_EN
  always_ff @(posedge clock) begin
    if (reset)               overflow <= 1'b0;
    else if (load && !ready) overflow <= 1'b1;
    else if (overflow_clear) overflow <= 1'b0;
  end
`endif

  count_tracks_full: assert property (@(posedge clock) disable iff (reset)
    count == popcount4(full));

endmodule

// File: tb/tb_register_scatter.sv
// Directed self-checking bench for register_scatter (n = 8).
module tb_register_scatter;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [1:0] select;
  logic [7:0] in;
  logic       ready;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] full;
  logic [3:0] ack;
  logic [2:0] count;
`ifdef REGISTER_SCATTER_OVERFLOW_EN
  logic       overflow_clear;
  logic       overflow;
`endif

  int checks   = 0;
  int failures = 0;

  register_scatter #(.n(8)) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef REGISTER_SCATTER_OVERFLOW_EN
    .overflow_clear (overflow_clear),
    .overflow       (overflow),
`endif
    .load           (load),
    .select         (select),
    .in             (in),
    .ready          (ready),
    .out0           (out0),
    .out1           (out1),
    .out2           (out2),
    .out3           (out3),
    .full           (full),
    .ack            (ack),
    .count          (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    load = 1'b0; ack = 4'b0000; select = 2'd0; in = 8'h00;
`ifdef REGISTER_SCATTER_OVERFLOW_EN
    overflow_clear = 1'b0;
`endif
  endtask

  task automatic write(input logic [1:0] s, input logic [7:0] d);
    load = 1'b1; select = s; in = d;
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_full", full, 4'b0000);
    chk("rst_count", count, 3'd0);
    chk("rst_out0", out0, 8'h00);
    chk("rst_out3", out3, 8'h00);
`ifdef REGISTER_SCATTER_OVERFLOW_EN
    chk("rst_ovf", overflow, 1'b0);
`endif

    // single write into slot 2
    write(2'd2, 8'hA5);
    chk("w2_out2", out2, 8'hA5);
    chk("w2_full", full, 4'b0100);
    chk("w2_count", count, 3'd1);
    chk("w2_out1", out1, 8'h00);

    // pass-through on a full slot with ack and write together
    ack = 4'b0100; load = 1'b1; select = 2'd2; in = 8'h33;
    #1 chk("pt2_ready", ready, 1'b1);
    tick(); idle();
    chk("pt2_out2", out2, 8'h33);
    chk("pt2_full", full, 4'b0100);
    chk("pt2_count", count, 3'd1);

    write(2'd0, 8'h11);
    write(2'd1, 8'h22);
    write(2'd3, 8'h44);
    chk("fill_full", full, 4'b1111);
    chk("fill_count", count, 3'd4);
    chk("fill_out0", out0, 8'h11);

    // rejected load when target slot is full and not acked
    load = 1'b1; select = 2'd1; in = 8'h99;
    #1 chk("rej_ready", ready, 1'b0);
    tick(); idle();
    chk("rej_out1", out1, 8'h22);
    chk("rej_count", count, 3'd4);
`ifdef REGISTER_SCATTER_OVERFLOW_EN
    chk("rej_ovf", overflow, 1'b1);
    tick();
    chk("ovf_sticky", overflow, 1'b1);
    overflow_clear = 1'b1;
    tick(); idle();
    chk("ovf_clear", overflow, 1'b0);
    load = 1'b1; select = 2'd0; overflow_clear = 1'b1;
    tick(); idle();
    chk("ovf_set_wins", overflow, 1'b1);
    overflow_clear = 1'b1;
    tick(); idle();
    chk("ovf_clear2", overflow, 1'b0);
`endif

    // slot 3 ack + write same cycle
    ack = 4'b1000; load = 1'b1; select = 2'd3; in = 8'h55;
    #1 chk("pt3_ready", ready, 1'b1);
    tick(); idle();
    chk("pt3_out3", out3, 8'h55);
    chk("pt3_full", full, 4'b1111);
    chk("pt3_count", count, 3'd4);

    // drain slot 2 alone; data holds
    ack = 4'b0100;
    tick(); idle();
    chk("d2_full", full, 4'b1011);
    chk("d2_count", count, 3'd3);
    chk("d2_out2", out2, 8'h33);

    // acks to 0,1,3 plus write to empty slot 2
    ack = 4'b1011; load = 1'b1; select = 2'd2; in = 8'h66;
    #1 chk("mix_ready", ready, 1'b1);
    tick(); idle();
    chk("mix_full", full, 4'b0100);
    chk("mix_count", count, 3'd1);
    chk("mix_out2", out2, 8'h66);
    chk("mix_out0_hold", out0, 8'h11);

    // ack on an empty slot does nothing
    ack = 4'b0001;
    tick(); idle();
    chk("ackempty_full", full, 4'b0100);
    chk("ackempty_count", count, 3'd1);

    // refill, create an overflow, then reset with load and all acks pending
    write(2'd0, 8'h01);
    write(2'd1, 8'h02);
    write(2'd3, 8'h03);
    chk("refill_full", full, 4'b1111);
    load = 1'b1; select = 2'd0; in = 8'hEE;
    tick(); idle();
    reset = 1'b1; load = 1'b1; select = 2'd1; in = 8'h77; ack = 4'b1111;
    tick();
    reset = 1'b0; idle();
    chk("rst2_full", full, 4'b0000);
    chk("rst2_count", count, 3'd0);
    chk("rst2_out1", out1, 8'h00);
    chk("rst2_out2", out2, 8'h00);
`ifdef REGISTER_SCATTER_OVERFLOW_EN
    chk("rst2_ovf", overflow, 1'b0);
`endif
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1 chk("rst2_ready", ready, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
